dmem_responder: RTL and testbench

Data-memory responder at the far end of the EX/MEM request lines (memEn, memWrEn, memAddr, wbyteen, wrdata) carried by the pipeline registers.
- Services one 128-bit word read or byte-masked write per request.
- Configurable access latency.
- Asserts stall to freeze the upstream pipeline until the access completes.
- Holds read data for the writeback mux.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_lane_merge.sv | 24 ++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory responder and
// the byte-lane write path it shares with the register file.
// Contents: word/byte geometry, processor-wide address width, FSM state
// type, and the request payload latched at the start of an access.
package dmem_pkg;

  localparam int unsigned WORD_W     = 128;
  localparam int unsigned NBYTES     = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DEF_ADDR_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Write payload captured at request accept; address is held separately
  // because its width is a module parameter.
  typedef struct packed {
    logic              we;
    logic [0:NBYTES-1] be;
    logic [0:WORD_W-1] data;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: EX/MEM request lines and responder return lines.
// Request (master -> slave): memEn, memWrEn, memAddr, wbyteen, wrdata.
// Response (slave -> master): rddata, rdvalid, stall, err.
// All vectors use ascending (bit 0 = MSB) numbering like the pipeline.
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              memEn;
  logic              memWrEn;
  logic [0:ADDR_W-1] memAddr;
  logic [0:NBYTES-1] wbyteen;
  logic [0:WORD_W-1] wrdata;
  logic [0:WORD_W-1] rddata;
  logic              rdvalid;
  logic              stall;
  logic              err;

  modport master (
    output memEn, memWrEn, memAddr, wbyteen, wrdata,
    input  rddata, rdvalid, stall, err
  );

  modport slave (
    input  memEn, memWrEn, memAddr, wbyteen, wrdata,
    output rddata, rdvalid, stall, err
  );

endinterface

// File: rtl/dmem_lane_merge.sv
// dmem_lane_merge: combinational byte-lane merge.
// Ports: old_word (current contents), new_word (write data),
//        lane_en (lane i selects bits [8i:8i+7] of new_word),
//        merged_c (result, combinational).
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [0:WORD_W-1] old_word,
  input  logic [0:WORD_W-1] new_word,
  input  logic [0:NBYTES-1] lane_en,
  output logic [0:WORD_W-1] merged_c
);

  // Start from the old word and overlay every enabled lane.
  always_comb begin
    merged_c = old_word;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (lane_en[i]) begin
        merged_c[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the EX/MEM request lines.
// Services one 128-bit read or byte-masked write per request after
// LATENCY busy cycles, holding the pipeline via stall until done.
// Ports: clk, reset (sync, active-high), bus (dmem_responder_if.slave).
// Optional: define DMEM_PERF_EN to add stall_cnt/acc_cnt outputs
// (saturating counts of stalled cycles and completed accesses).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic clk,
  input  logic reset,
  dmem_responder_if.slave bus
`ifdef DMEM_PERF_EN
  ,
  output logic [0:31] stall_cnt,
  output logic [0:31] acc_cnt
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  dmem_req_t         req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [0:WORD_W-1] mem [DEPTH];
  logic [0:WORD_W-1] rd_word;
  logic [0:WORD_W-1] merged_word;
  logic              accept;
  logic              fire;
  logic              in_range;
  logic [AW-1:0]     mem_idx;

  // Accept only from IDLE; fire on the last BUSY cycle unless reset aborts.
  assign accept   = (state_q == IDLE) && bus.memEn && !reset;
  assign fire     = (state_q == BUSY) && (cnt_q == '0) && !reset;
  // No aliasing: any address at or above DEPTH is rejected outright.
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign mem_idx  = addr_q[AW-1:0];
  assign rd_word  = mem[mem_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE ignores the still-held request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.memEn) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: pipeline hold.
  always_comb begin
    bus.stall = 1'b0;
    if (!reset) begin
      bus.stall = ((state_q == IDLE) && bus.memEn) || (state_q == BUSY);
    end
  end

  // Latency counter.
  always_ff @(posedge clk) begin
    if (reset)                                cnt_q <= '0;
    else if (accept)                          cnt_q <= CNT_W'(LATENCY - 1);
    else if (state_q == BUSY && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  // Request capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q.we   <= bus.memWrEn;
      req_q.be   <= bus.wbyteen;
      req_q.data <= bus.wrdata;
      addr_q     <= bus.memAddr;
    end
  end

  dmem_lane_merge u_lane_merge (
    .old_word (rd_word),
    .new_word (req_q.data),
    .lane_en  (req_q.be),
    .merged_c (merged_word)
  );

  // Array write; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (fire && in_range && req_q.we) mem[mem_idx] <= merged_word;
  end

  // Registered response; rddata only changes on a completed read.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rddata  <= '0;
      bus.rdvalid <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.rdvalid <= 1'b0;
      bus.err     <= 1'b0;
      if (fire) begin
        bus.err <= !in_range;
        if (!req_q.we) begin
          bus.rdvalid <= 1'b1;
          bus.rddata  <= in_range ? rd_word : '0;
        end
      end
    end
  end

`ifdef DMEM_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      acc_cnt   <= '0;
    end else begin
      if (bus.stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (fire && acc_cnt != '1)        acc_cnt   <= acc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Three instances (LATENCY 1/2/3, DEPTH 256) share one request stream;
// each test selects the instance whose responses it inspects.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic              clk;
  logic              reset;
  logic              req_en;
  logic              req_we;
  logic [0:20]       req_addr;
  logic [0:15]       req_be;
  logic [0:127]      req_data;
  int                tests_run;
  int                tests_failed;

  localparam logic [0:127] D_FULL = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [0:127] D_ONES = {128{1'b1}};
  localparam logic [0:127] D_PART = 128'h00FFFFFFFFFFFFFFFFFFFFFFFFFFFF00;
  localparam logic [0:127] D_A0   = 128'hA5A5_0102_0304_0506_0708_090A_0B0C_5A5A;
  localparam logic [0:127] D_Q    = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;

  dmem_responder_if #(.ADDR_W(21)) b1 ();
  dmem_responder_if #(.ADDR_W(21)) b2 ();
  dmem_responder_if #(.ADDR_W(21)) b3 ();

  assign b1.memEn = req_en;  assign b1.memWrEn = req_we;  assign b1.memAddr = req_addr;
  assign b1.wbyteen = req_be; assign b1.wrdata = req_data;
  assign b2.memEn = req_en;  assign b2.memWrEn = req_we;  assign b2.memAddr = req_addr;
  assign b2.wbyteen = req_be; assign b2.wrdata = req_data;
  assign b3.memEn = req_en;  assign b3.memWrEn = req_we;  assign b3.memAddr = req_addr;
  assign b3.wbyteen = req_be; assign b3.wrdata = req_data;

`ifdef DMEM_PERF_EN
  logic [0:31] sc1, ac1, sc2, ac2, sc3, ac3;
`endif

  dmem_responder #(.DEPTH(256), .LATENCY(1), .ADDR_W(21)) u_l1 (
    .clk(clk), .reset(reset), .bus(b1)
`ifdef DMEM_PERF_EN
    , .stall_cnt(sc1), .acc_cnt(ac1)
`endif
  );
  dmem_responder #(.DEPTH(256), .LATENCY(2), .ADDR_W(21)) u_l2 (
    .clk(clk), .reset(reset), .bus(b2)
`ifdef DMEM_PERF_EN
    , .stall_cnt(sc2), .acc_cnt(ac2)
`endif
  );
  dmem_responder #(.DEPTH(256), .LATENCY(3), .ADDR_W(21)) u_l3 (
    .clk(clk), .reset(reset), .bus(b3)
`ifdef DMEM_PERF_EN
    , .stall_cnt(sc3), .acc_cnt(ac3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Issue one request on the shared lines, hold it until instance `which`
  // leaves stall, and report what that instance showed in its DONE cycle.
  task automatic access(input int which, input logic we, input logic [0:20] addr,
                        input logic [0:15] be, input logic [0:127] data,
                        output int n_stall, output int done_cyc, output logic rv,
                        output logic er, output logic [0:127] rd);
    logic s, v, e;
    logic [0:127] d;
    n_stall = 0; done_cyc = -1; rv = 1'b0; er = 1'b0; rd = '0;
    @(negedge clk);
    req_en = 1'b1; req_we = we; req_addr = addr; req_be = be; req_data = data;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      case (which)
        1:       begin s = b1.stall; v = b1.rdvalid; e = b1.err; d = b1.rddata; end
        3:       begin s = b3.stall; v = b3.rdvalid; e = b3.err; d = b3.rddata; end
        default: begin s = b2.stall; v = b2.rdvalid; e = b2.err; d = b2.rddata; end
      endcase
      if (s) n_stall++;
      else begin
        done_cyc = c; rv = v; er = e; rd = d;
        break;
      end
    end
    @(negedge clk);
    req_en = 1'b0;
    idle(6);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req_en = 1'b1; req_we = 1'b0; req_addr = '0; req_be = '0; req_data = '0;
    idle(2);
    #1;
    tests_run++; if (b2.stall !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_in_reset: got %b want 0", b2.stall); end
    @(negedge clk);
    reset = 1'b0; req_en = 1'b0;
    #1;
    tests_run++; if (b2.rddata !== 128'h0) begin tests_failed++; $display("FAIL rst_rddata: got %h want 0", b2.rddata); end
    tests_run++; if (b2.rdvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_rdvalid: got %b want 0", b2.rdvalid); end
    tests_run++; if (b2.err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", b2.err); end
    tests_run++; if (b2.stall !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_idle: got %b want 0", b2.stall); end
  endtask

  task automatic test_write_read();
    int ns, dc; logic rv, er; logic [0:127] rd;
    access(2, 1'b1, 21'd5, 16'hFFFF, D_FULL, ns, dc, rv, er, rd);
    tests_run++; if (ns !== 3) begin tests_failed++; $display("FAIL wr_stall_cycles: got %0d want 3", ns); end
    tests_run++; if (dc !== 3 || rv !== 1'b0 || er !== 1'b0) begin tests_failed++; $display("FAIL wr_done: got cyc=%0d rv=%b err=%b want cyc=3 rv=0 err=0", dc, rv, er); end
    access(2, 1'b0, 21'd5, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (ns !== 3) begin tests_failed++; $display("FAIL rd_stall_cycles: got %0d want 3", ns); end
    tests_run++; if (dc !== 3 || rv !== 1'b1) begin tests_failed++; $display("FAIL rd_valid: got cyc=%0d rv=%b want cyc=3 rv=1", dc, rv); end
    tests_run++; if (rd !== D_FULL) begin tests_failed++; $display("FAIL rd_data: got %h want %h", rd, D_FULL); end
    #1;
    tests_run++; if (b2.rdvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_pulse: got %b want 0", b2.rdvalid); end
  endtask

  task automatic test_partial_write();
    int ns, dc; logic rv, er; logic [0:127] rd;
    access(2, 1'b1, 21'd7, 16'hFFFF, D_ONES, ns, dc, rv, er, rd);
    tests_run++; if (rd !== D_FULL) begin tests_failed++; $display("FAIL wr_keeps_rddata: got %h want %h", rd, D_FULL); end
    access(2, 1'b1, 21'd7, 16'h8001, '0, ns, dc, rv, er, rd);
    access(2, 1'b0, 21'd7, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (rd !== D_PART || rv !== 1'b1) begin tests_failed++; $display("FAIL partial_data: got %h rv=%b want %h rv=1", rd, rv, D_PART); end
    access(2, 1'b1, 21'd7, 16'h0000, '0, ns, dc, rv, er, rd);
    access(2, 1'b0, 21'd7, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (rd !== D_PART) begin tests_failed++; $display("FAIL noop_write: got %h want %h", rd, D_PART); end
  endtask

  task automatic test_out_of_range();
    int ns, dc; logic rv, er; logic [0:127] rd;
    access(2, 1'b1, 21'd0, 16'hFFFF, D_A0, ns, dc, rv, er, rd);
    access(2, 1'b1, 21'd256, 16'hFFFF, '0, ns, dc, rv, er, rd);
    tests_run++; if (er !== 1'b1 || rv !== 1'b0) begin tests_failed++; $display("FAIL oor_wr_err: got err=%b rv=%b want err=1 rv=0", er, rv); end
    access(2, 1'b0, 21'd256, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (er !== 1'b1 || rv !== 1'b1 || rd !== 128'h0) begin tests_failed++; $display("FAIL oor_rd: got err=%b rv=%b data=%h want err=1 rv=1 data=0", er, rv, rd); end
    access(2, 1'b0, 21'd0, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (rd !== D_A0 || er !== 1'b0) begin tests_failed++; $display("FAIL oor_no_alias: got %h err=%b want %h err=0", rd, er, D_A0); end
    access(2, 1'b0, 21'd255, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (er !== 1'b0 || rv !== 1'b1) begin tests_failed++; $display("FAIL top_addr_in_range: got err=%b rv=%b want err=0 rv=1", er, rv); end
  endtask

  task automatic test_held_request();
    logic [9:0] pulses;
    logic       data_ok;
    pulses = '0; data_ok = 1'b1;
    @(negedge clk);
    req_en = 1'b1; req_we = 1'b0; req_addr = 21'd5; req_be = '0; req_data = '0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (b1.rdvalid === 1'b1) begin
        pulses[c] = 1'b1;
        if (b1.rddata !== D_FULL) data_ok = 1'b0;
      end
    end
    @(negedge clk);
    req_en = 1'b0;
    idle(6);
    tests_run++; if (pulses !== 10'h124) begin tests_failed++; $display("FAIL held_pulses: got %b want %b", pulses, 10'h124); end
    tests_run++; if (data_ok !== 1'b1) begin tests_failed++; $display("FAIL held_data: got bad rddata want %h", D_FULL); end
  endtask

  task automatic test_reset_mid_busy();
    int ns, dc; logic rv, er; logic [0:127] rd;
    logic saw_rv;
    saw_rv = 1'b0;
    access(2, 1'b1, 21'd9, 16'hFFFF, D_Q, ns, dc, rv, er, rd);
    @(negedge clk);
    req_en = 1'b1; req_we = 1'b1; req_addr = 21'd9; req_be = 16'hFFFF; req_data = '0;
    @(negedge clk);
    reset = 1'b1; req_en = 1'b0;
    #1;
    tests_run++; if (b2.stall !== 1'b0) begin tests_failed++; $display("FAIL abort_stall_in_reset: got %b want 0", b2.stall); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (b2.rdvalid === 1'b1 || b2.stall !== 1'b0) saw_rv = 1'b1;
      @(negedge clk);
    end
    tests_run++; if (saw_rv !== 1'b0) begin tests_failed++; $display("FAIL abort_quiet: got rdvalid/stall activity want none"); end
    access(2, 1'b0, 21'd9, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (dc !== 3 || rd !== D_Q) begin tests_failed++; $display("FAIL abort_no_write: got cyc=%0d data=%h want cyc=3 data=%h", dc, rd, D_Q); end
  endtask

`ifdef DMEM_PERF_EN
  task automatic test_perf();
    int ns, dc; logic rv, er; logic [0:127] rd;
    @(negedge clk);
    reset = 1'b1; req_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++; if (sc3 !== 32'd0 || ac3 !== 32'd0) begin tests_failed++; $display("FAIL perf_reset: got stall_cnt=%0d acc_cnt=%0d want 0 0", sc3, ac3); end
    access(3, 1'b0, 21'd5, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (ns !== 4 || dc !== 4 || rd !== D_FULL) begin tests_failed++; $display("FAIL perf_l3_read: got ns=%0d cyc=%0d data=%h want 4 4 %h", ns, dc, rd, D_FULL); end
    access(3, 1'b0, 21'd5, 16'h0, '0, ns, dc, rv, er, rd);
    tests_run++; if (ac3 !== 32'd2) begin tests_failed++; $display("FAIL perf_acc_cnt: got %0d want 2", ac3); end
    tests_run++; if (sc3 !== 32'd8) begin tests_failed++; $display("FAIL perf_stall_cnt: got %0d want 8", sc3); end
  endtask
`endif

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; req_en = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_data = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_held_request();
    test_reset_mid_busy();
`ifdef DMEM_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
